// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers and a fixed commit latency.
// Define MDU_MADD_EN to enable madd/maddu (ops 7/8); otherwise those codes are reserved.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int W2    = 2 * WIDTH;
    localparam int MAXC  = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW    = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, sh_q, sl_q;
    logic             busy_q, done_q, wr_q;

    logic             madd_en, is_mul, is_div, sdiv, smul, acc_en;
    logic [W2-1:0]    prod, mul_d, div_d;
    logic [WIDTH-1:0] ma, mb, qm, rm, q, r;

`ifdef MDU_MADD_EN
    assign madd_en = 1'b1;
`else
    assign madd_en = 1'b0;
`endif

    always_comb begin
        acc_en = madd_en && (MDUOp == 4'd7 || MDUOp == 4'd8);
        is_mul = MDUOp == 4'd1 || MDUOp == 4'd2 || acc_en;
        is_div = MDUOp == 4'd3 || MDUOp == 4'd4;
        smul   = MDUOp == 4'd1 || MDUOp == 4'd7;
        sdiv   = MDUOp == 4'd3;
        // Low 2W bits of the product of sign-extended operands give the signed product.
        prod   = smul ? {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B}
                      : {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        mul_d  = prod + (acc_en ? {hi_q, lo_q} : {W2{1'b0}});
        // Sign-magnitude division; the most-negative/-1 case wraps naturally to -2^(W-1), rem 0.
        ma     = (sdiv && A[WIDTH-1]) ? -A : A;
        mb     = (B == '0) ? WIDTH'(1) : ((sdiv && B[WIDTH-1]) ? -B : B);
        qm     = ma / mb;
        rm     = ma % mb;
        q      = (sdiv && (A[WIDTH-1] ^ B[WIDTH-1])) ? -qm : qm;
        r      = (sdiv && A[WIDTH-1]) ? -rm : rm;
        div_d  = {r, q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sh_q    <= '0;
            sl_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
        end else if (state_q == IDLE) begin
            done_q <= 1'b0;
            if (Start && (is_mul || is_div)) begin
                {sh_q, sl_q} <= is_mul ? mul_d : div_d;
                cnt_q        <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                wr_q         <= is_mul || B != '0;
                busy_q       <= 1'b1;
                state_q      <= RUN;
            end else if (Start && MDUOp == 4'd5) begin
                hi_q <= A;
            end else if (Start && MDUOp == 4'd6) begin
                lo_q <= A;
            end
        end else if (cnt_q == CW'(1)) begin
            if (wr_q) begin
                hi_q <= sh_q;
                lo_q <= sl_q;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
        end else begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule
